// File: rtl/led_pwm_pkg.sv
// Shared types and helpers for the LED PWM driver.
// The squaring helper is only referenced when LED_PWM_GAMMA_EN is defined.
package led_pwm_pkg;

  localparam int unsigned DUTY_W = 8;

  typedef logic [DUTY_W-1:0] duty_t;

  localparam duty_t PWM_MAX = 8'd255;

  // Perceptual brightness curve: upper byte of the 16-bit square.
  function automatic duty_t gamma_sq(input duty_t d);
    logic [2*DUTY_W-1:0] sq;
    sq = {{DUTY_W{1'b0}}, d} * {{DUTY_W{1'b0}}, d};
    return sq[2*DUTY_W-1:DUTY_W];
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One PWM channel: shadow/active duty pair, compare and registered LED output.
// With LED_PWM_GAMMA_EN defined the shadow value is squared on its way to active.
module led_pwm_channel
  import led_pwm_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [DUTY_W-1:0] wr_data_i,
  input  logic              update_i,
  input  logic [DUTY_W-1:0] pwm_cnt_i,
  output logic              led_o
);

  duty_t shadow_q, shadow_d;
  duty_t active_q, active_d;
  duty_t next_active;
  logic  led_q, led_d;

  // Computed from shadow so active still loads on the update edge itself.
  always_comb begin
`ifdef LED_PWM_GAMMA_EN
    next_active = gamma_sq(shadow_q);
`else
    next_active = shadow_q;
`endif
  end

  always_comb begin
    shadow_d = we_i ? wr_data_i : shadow_q;
    active_d = update_i ? next_active : active_q;
    led_d    = (pwm_cnt_i < active_q);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shadow_q <= '0;
      active_q <= '0;
      led_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      led_q    <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/led_pwm_driver.sv
// Per-LED PWM brightness driver with double-buffered duties swapped at period boundaries.
// Optional gamma curve selected by defining LED_PWM_GAMMA_EN.
module led_pwm_driver
  import led_pwm_pkg::*;
#(
  parameter int unsigned NUM_LED  = 8,
  parameter int unsigned PRESCALE = 4,
  localparam int unsigned AddrW   = (NUM_LED > 1) ? $clog2(NUM_LED) : 1
) (
  input  logic               clk_25mhz,
  input  logic               rst_n,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [AddrW-1:0]   wr_addr,
  input  logic [DUTY_W-1:0]  wr_data,
  output logic [NUM_LED-1:0] led,
  output logic               period_start
);

  localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PsW-1:0] PsLast = PsW'(PRESCALE - 1);

  logic [PsW-1:0] prescale_q, prescale_d;
  duty_t          pwm_cnt_q, pwm_cnt_d;
  logic           run_q, run_d;
  logic           period_start_q, period_start_d;
  logic           tick, update, wr_fire;

  always_comb begin
    tick   = (prescale_q == PsLast);
    update = tick && (pwm_cnt_q == PWM_MAX);
  end

  // Ready depends on registered state only; it drops for the single update cycle.
  assign wr_ready = run_q && !update;
  assign wr_fire  = wr_valid && wr_ready;

  always_comb begin
    prescale_d     = tick ? '0 : prescale_q + 1'b1;
    pwm_cnt_d      = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    run_d          = 1'b1;
    period_start_d = update;
  end

  always_ff @(posedge clk_25mhz) begin
    if (!rst_n) begin
      prescale_q     <= '0;
      pwm_cnt_q      <= '0;
      run_q          <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      prescale_q     <= prescale_d;
      pwm_cnt_q      <= pwm_cnt_d;
      run_q          <= run_d;
      period_start_q <= period_start_d;
    end
  end

  assign period_start = period_start_q;

  // Addresses beyond NUM_LED-1 match no channel, so such writes are accepted and dropped.
  for (genvar i = 0; i < NUM_LED; i++) begin : g_chan
    logic we;
    assign we = wr_fire && (wr_addr == AddrW'(i));

    led_pwm_channel u_chan (
      .clk_i     (clk_25mhz),
      .rst_ni    (rst_n),
      .we_i      (we),
      .wr_data_i (wr_data),
      .update_i  (update),
      .pwm_cnt_i (pwm_cnt_q),
      .led_o     (led[i])
    );
  end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Scoreboard bench: stimulus queues expected per-period LED high counts, a monitor
// measures each PWM period on both a PRESCALE=1 and a PRESCALE=4 instance and compares.
module tb_led_pwm_driver;

  logic       clk;
  logic       rst_n;
  logic       wr_valid1, wr_valid4;
  logic       wr_ready1, wr_ready4;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] led1, led4;
  logic       ps1, ps4;

  led_pwm_driver #(.NUM_LED(8), .PRESCALE(1)) u_dut1 (
    .clk_25mhz    (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid1),
    .wr_ready     (wr_ready1),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .led          (led1),
    .period_start (ps1)
  );

  led_pwm_driver #(.NUM_LED(8), .PRESCALE(4)) u_dut4 (
    .clk_25mhz    (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid4),
    .wr_ready     (wr_ready4),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .led          (led4),
    .period_start (ps4)
  );

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  initial begin
    #(60000 * 40);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct packed {
    int              dut;
    int              win;
    logic [7:0][15:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_cmp  = 0;
  int  n_fail = 0;
  int  win[2];
  bit  open[2];
  bit  rel[2];
  int  cnt[2][8];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int d, input int w, input logic [7:0][15:0] e);
    sb_t s;
    s.dut = d;
    s.win = w;
    s.exp = e;
    sb.push_back(s);
  endtask

  task automatic finalize(input int d);
    int k;
    k = 0;
    while (k < sb.size()) begin
      if (sb[k].dut == d && sb[k].win <= win[d]) begin
        if (sb[k].win < win[d]) begin
          chk($sformatf("d%0d_stale_window", d), sb[k].win, win[d]);
        end else begin
          for (int i = 0; i < 8; i++) begin
            chk($sformatf("d%0d_win%0d_led%0d_high", d, win[d], i), cnt[d][i],
                int'(sb[k].exp[i]));
          end
        end
        sb.delete(k);
      end else begin
        k++;
      end
    end
  endtask

  // Monitor: a window opens at reset release or period_start and closes at the next period_start.
  initial begin
    logic [7:0] lv;
    logic       psv;
    win  = '{0, 0};
    open = '{0, 0};
    rel  = '{1, 1};
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        lv  = (d == 0) ? led1 : led4;
        psv = (d == 0) ? ps1 : ps4;
        if (!rst_n) begin
          open[d] = 1'b0;
          rel[d]  = 1'b1;
        end else begin
          if (rel[d] || psv) begin
            if (open[d] && psv) finalize(d);
            rel[d]  = 1'b0;
            open[d] = 1'b1;
            win[d]++;
            for (int i = 0; i < 8; i++) cnt[d][i] = 0;
          end
          if (open[d]) begin
            for (int i = 0; i < 8; i++) cnt[d][i] += int'(lv[i]);
          end
        end
      end
    end
  end

  task automatic do_write(input int d, input int a, input int v);
    bit acc;
    wr_addr = 3'(a);
    wr_data = 8'(v);
    if (d == 0) wr_valid1 = 1'b1;
    else        wr_valid4 = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 10 && !acc; n++) begin
      acc = (d == 0) ? wr_ready1 : wr_ready4;
      @(posedge clk);
      #1;
    end
    wr_valid1 = 1'b0;
    wr_valid4 = 1'b0;
    chk($sformatf("d%0d_write_accept_a%0d", d, a), int'(acc), 1);
  endtask

  task automatic wait_ps(input int d);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 3000 && !seen; n++) begin
      @(negedge clk);
      seen = (d == 0) ? ps1 : ps4;
    end
    #1;
    chk($sformatf("d%0d_period_start_seen", d), int'(seen), 1);
  endtask

  initial begin
    logic [7:0][15:0] e;
    int w;
    int g128, g255, g15;
`ifdef LED_PWM_GAMMA_EN
    g128 = 64;  g255 = 254; g15 = 0;
`else
    g128 = 128; g255 = 255; g15 = 15;
`endif

    // Reset held with a pending write: nothing accepted, outputs quiet.
    rst_n     = 1'b0;
    wr_valid1 = 1'b1;
    wr_valid4 = 1'b0;
    wr_addr   = 3'd2;
    wr_data   = 8'd99;
    repeat (5) @(negedge clk);
    #1;
    chk("rst_led1", int'(led1), 0);
    chk("rst_ready1", int'(wr_ready1), 0);
    chk("rst_ps1", int'(ps1), 0);
    chk("rst_led4", int'(led4), 0);
    chk("rst_ready4", int'(wr_ready4), 0);
    wr_valid1 = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    #1;
    chk("release_ready1", int'(wr_ready1), 1);
    chk("release_ready4", int'(wr_ready4), 1);
    e = '0;
    push(0, win[0], e);
    push(1, win[1], e);

    // Basic duty written mid-period: invisible this period, 64 high next period.
    wait_ps(0);
    w = win[0];
    repeat (100) @(negedge clk);
    #1;
    do_write(0, 3, 64);
    e = '0;
    push(0, w, e);
    e[3] = 16'd64;
    push(0, w + 1, e);
    wait_ps(0);
    wait_ps(0);

    // Extremes: duty 0 never lights, duty 255 lights 255 of 256.
    w = win[0];
    do_write(0, 0, 0);
    do_write(0, 7, 255);
    e = '0;
    e[3] = 16'd64;
    push(0, w, e);
    e[7] = 16'd255;
    push(0, w + 1, e);
    wait_ps(0);
    wait_ps(0);

    // Write presented on the update cycle: stalled one cycle, lands a period later.
    w = win[0];
    e = '0;
    e[3] = 16'd64;
    e[7] = 16'd255;
    push(0, w, e);
    push(0, w + 1, e);
    e[1] = 16'd200;
    push(0, w + 2, e);
    repeat (255) @(negedge clk);
    #1;
    wr_addr   = 3'd1;
    wr_data   = 8'd200;
    wr_valid1 = 1'b1;
    chk("update_cycle_ready", int'(wr_ready1), 0);
    @(negedge clk);
    #1;
    chk("post_update_period_start", int'(ps1), 1);
    chk("post_update_ready", int'(wr_ready1), 1);
    @(posedge clk);
    #1;
    wr_valid1 = 1'b0;
    wait_ps(0);
    wait_ps(0);

    // PRESCALE=4: duty 100 -> 400 of 1024, then reset mid high phase.
    wait_ps(1);
    w = win[1];
    do_write(1, 2, 100);
    e = '0;
    push(1, w, e);
    e[2] = 16'd400;
    push(1, w + 1, e);
    wait_ps(1);
    wait_ps(1);
    repeat (200) @(negedge clk);
    #1;
    chk("p4_high_before_reset", int'(led4[2]), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("p4_led_after_reset_edge", int'(led4), 0);
    chk("p1_led_after_reset_edge", int'(led1), 0);
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    e = '0;
    push(0, win[0], e);
    push(1, win[1], e);
    push(1, win[1] + 1, e);
    wait_ps(1);
    wait_ps(1);

    // Brightness curve (identity when the gamma build option is off).
    wait_ps(0);
    w = win[0];
    do_write(0, 0, 128);
    do_write(0, 7, 255);
    do_write(0, 5, 15);
    e = '0;
    push(0, w, e);
    e[0] = 16'(g128);
    e[7] = 16'(g255);
    e[5] = 16'(g15);
    push(0, w + 1, e);
    wait_ps(0);
    wait_ps(0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
